// File: rtl/mem_stall_pkg.sv
// Shared types and default widths for the memory-stage stall controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_stall_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    TAG   = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/line_word_cnt.sv
// Word-within-line counter for cache line fills, with a last-word flag.
// Latency: count updates on the clock edge after clear/enable; last flag is combinational.
// Backpressure: none; advances only when enabled.
module line_word_cnt #(
  parameter int LINE_WORDS = 4,
  parameter int OFFSET_W   = $clog2(LINE_WORDS)
) (
  input  logic                inp_clk,
  input  logic                inp_rstn,
  input  logic                inp_clr,
  input  logic                inp_en,
  output logic [OFFSET_W-1:0] out_cnt,
  output logic                out_last
);

  logic [OFFSET_W-1:0] cntQ;

  // Counter register; clear wins over enable, and the count wraps naturally
  // because LINE_WORDS is a power of two.
  always_ff @(posedge inp_clk) begin
    if (!inp_rstn) begin
      cntQ <= '0;
    end else if (inp_clr) begin
      cntQ <= '0;
    end else if (inp_en) begin
      cntQ <= cntQ + 1'b1;
    end
  end

  assign out_cnt  = cntQ;
  assign out_last = (cntQ == OFFSET_W'(LINE_WORDS - 1));

endmodule

// File: rtl/mem_stall_ctrl.sv
// MEM-stage controller: pipeline enable, read-miss line fill, write-through stores.
// Latency: read hit 0 stalls; read miss LINE_WORDS acks + 2; write ack latency + 1.
// Backpressure: out_hit=0 stalls the pipeline; memory side is req held until ack. Optional MEM_STALL_MISS_CNT_EN adds out_missCnt.
module mem_stall_ctrl
  import mem_stall_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LINE_WORDS = 4,
  parameter int OFFSET_W   = $clog2(LINE_WORDS)
) (
  input  logic                inp_clk,
  input  logic                inp_rstn,
  input  logic                inp_memRead,
  input  logic                inp_memWrite,
  input  logic [ADDR_W-1:0]   inp_addr,
  input  logic [DATA_W-1:0]   inp_wdata,
  input  logic                inp_tagHit,
  input  logic                inp_memAck,
  input  logic [DATA_W-1:0]   inp_memData,
  output logic                out_hit,
  output logic                out_memReq,
  output logic                out_memWe,
  output logic [ADDR_W-1:0]   out_memAddr,
  output logic [DATA_W-1:0]   out_memWdata,
  output logic                out_fillWe,
  output logic [OFFSET_W-1:0] out_fillIdx,
  output logic [DATA_W-1:0]   out_fillData,
  output logic                out_tagWe
`ifdef MEM_STALL_MISS_CNT_EN
  ,
  output logic [15:0]         out_missCnt
`endif
);

  state_t              stateQ, stateNxt;
  logic [ADDR_W-1:0]   addrQ;
  logic [DATA_W-1:0]   wdataQ;
  logic                cntClr, cntEn, cntLast, missStart;
  logic [OFFSET_W-1:0] cnt;

  line_word_cnt #(
    .LINE_WORDS(LINE_WORDS),
    .OFFSET_W  (OFFSET_W)
  ) u_cnt (
    .inp_clk (inp_clk),
    .inp_rstn(inp_rstn),
    .inp_clr (cntClr),
    .inp_en  (cntEn),
    .out_cnt (cnt),
    .out_last(cntLast)
  );

  // State register plus request latching; a miss stores only the line base.
  always_ff @(posedge inp_clk) begin
    if (!inp_rstn) begin
      stateQ <= IDLE;
      addrQ  <= '0;
      wdataQ <= '0;
    end else begin
      stateQ <= stateNxt;
      if (stateQ == IDLE && inp_memWrite) begin
        addrQ  <= inp_addr;
        wdataQ <= inp_wdata;
      end else if (missStart) begin
        addrQ  <= {inp_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
      end
    end
  end

  // Next-state and output decode; ack is only honoured in states that request.
  always_comb begin
    stateNxt     = stateQ;
    out_hit      = 1'b0;
    out_memReq   = 1'b0;
    out_memWe    = 1'b0;
    out_memAddr  = '0;
    out_memWdata = '0;
    out_fillWe   = 1'b0;
    out_fillIdx  = '0;
    out_fillData = '0;
    out_tagWe    = 1'b0;
    cntClr       = 1'b0;
    cntEn        = 1'b0;
    missStart    = 1'b0;
    case (stateQ)
      IDLE: begin
        if (inp_memWrite) begin
          stateNxt = WRITE;
        end else if (inp_memRead && !inp_tagHit) begin
          stateNxt  = FILL;
          cntClr    = 1'b1;
          missStart = 1'b1;
        end else begin
          // No request, or a read that hits: complete this cycle.
          out_hit = 1'b1;
        end
      end
      FILL: begin
        out_memReq  = 1'b1;
        out_memAddr = {addrQ[ADDR_W-1:OFFSET_W], cnt};
        if (inp_memAck) begin
          out_fillWe   = 1'b1;
          out_fillIdx  = cnt;
          out_fillData = inp_memData;
          cntEn        = 1'b1;
          if (cntLast) stateNxt = TAG;
        end
      end
      TAG: begin
        out_tagWe = 1'b1;
        stateNxt  = DONE;
      end
      WRITE: begin
        out_memReq   = 1'b1;
        out_memWe    = 1'b1;
        out_memAddr  = addrQ;
        out_memWdata = wdataQ;
        if (inp_memAck) begin
          stateNxt = DONE;
          // Keep a resident line coherent with the written-through word.
          if (inp_tagHit) begin
            out_fillWe   = 1'b1;
            out_fillIdx  = addrQ[OFFSET_W-1:0];
            out_fillData = wdataQ;
          end
        end
      end
      DONE: begin
        out_hit  = 1'b1;
        stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

`ifdef MEM_STALL_MISS_CNT_EN
  logic [15:0] missCntQ;

  // Saturating count of line fills started.
  always_ff @(posedge inp_clk) begin
    if (!inp_rstn) begin
      missCntQ <= '0;
    end else if (missStart && missCntQ != 16'hFFFF) begin
      missCntQ <= missCntQ + 16'd1;
    end
  end

  assign out_missCnt = missCntQ;
`endif

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed bench for mem_stall_ctrl: table of per-cycle vectors plus a reset-mid-fill sequence.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_stall_ctrl;

  logic        inp_clk = 1'b0;
  logic        inp_rstn;
  logic        inp_memRead, inp_memWrite, inp_tagHit, inp_memAck;
  logic [15:0] inp_addr, inp_wdata, inp_memData;
  logic        out_hit, out_memReq, out_memWe, out_fillWe, out_tagWe;
  logic [15:0] out_memAddr, out_memWdata, out_fillData;
  logic [1:0]  out_fillIdx;
`ifdef MEM_STALL_MISS_CNT_EN
  logic [15:0] out_missCnt;
`endif

  int checks = 0;
  int passed = 0;

  mem_stall_ctrl dut (
    .inp_clk     (inp_clk),
    .inp_rstn    (inp_rstn),
    .inp_memRead (inp_memRead),
    .inp_memWrite(inp_memWrite),
    .inp_addr    (inp_addr),
    .inp_wdata   (inp_wdata),
    .inp_tagHit  (inp_tagHit),
    .inp_memAck  (inp_memAck),
    .inp_memData (inp_memData),
    .out_hit     (out_hit),
    .out_memReq  (out_memReq),
    .out_memWe   (out_memWe),
    .out_memAddr (out_memAddr),
    .out_memWdata(out_memWdata),
    .out_fillWe  (out_fillWe),
    .out_fillIdx (out_fillIdx),
    .out_fillData(out_fillData),
    .out_tagWe   (out_tagWe)
`ifdef MEM_STALL_MISS_CNT_EN
    ,
    .out_missCnt (out_missCnt)
`endif
  );

  always #5 inp_clk = ~inp_clk;

  typedef struct {
    logic        rstn, rd, wr, tag, ack;
    logic [15:0] memData, addr, wdata;
    logic        eHit, eReq, eWe;
    logic [15:0] eAddr, eWdata;
    logic        eFillWe;
    logic [1:0]  eIdx;
    logic [15:0] eFillData;
    logic        eTagWe;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  function automatic logic [63:0] outVec();
    return {9'd0, out_hit, out_memReq, out_memWe, out_memAddr, out_memWdata,
            out_fillWe, out_fillIdx, out_fillData, out_tagWe};
  endfunction

  function automatic logic [63:0] expVec(input vec_t v);
    return {9'd0, v.eHit, v.eReq, v.eWe, v.eAddr, v.eWdata,
            v.eFillWe, v.eIdx, v.eFillData, v.eTagWe};
  endfunction

  initial begin
    inp_rstn = 1'b0; inp_memRead = 1'b0; inp_memWrite = 1'b0; inp_tagHit = 1'b0;
    inp_memAck = 1'b0; inp_addr = '0; inp_wdata = '0; inp_memData = '0;

    // rstn rd wr tag ack memData addr wdata | hit req we addr wdata fwe idx fdata tagwe
    // reset, idle
    tbl.push_back(vec_t'{0,0,0,0,0,16'h0,16'h0,16'h0,   1,0,0,16'h0,16'h0,0,2'd0,16'h0,0});
    tbl.push_back(vec_t'{0,0,0,0,0,16'h0,16'h0,16'h0,   1,0,0,16'h0,16'h0,0,2'd0,16'h0,0});
    // read hit 0x0042
    tbl.push_back(vec_t'{1,1,0,1,0,16'h0,16'h0042,16'h0,1,0,0,16'h0,16'h0,0,2'd0,16'h0,0});
    tbl.push_back(vec_t'{1,0,0,0,0,16'h0,16'h0,16'h0,   1,0,0,16'h0,16'h0,0,2'd0,16'h0,0});
    // read miss 0x0047, acks every cycle
    tbl.push_back(vec_t'{1,1,0,0,0,16'h0,16'h0047,16'h0,  0,0,0,16'h0,16'h0,0,2'd0,16'h0,0});
    tbl.push_back(vec_t'{1,1,0,0,1,16'hA0,16'h0047,16'h0, 0,1,0,16'h0044,16'h0,1,2'd0,16'hA0,0});
    tbl.push_back(vec_t'{1,1,0,0,1,16'hA1,16'h0047,16'h0, 0,1,0,16'h0045,16'h0,1,2'd1,16'hA1,0});
    tbl.push_back(vec_t'{1,1,0,0,1,16'hA2,16'h0047,16'h0, 0,1,0,16'h0046,16'h0,1,2'd2,16'hA2,0});
    tbl.push_back(vec_t'{1,1,0,0,1,16'hA3,16'h0047,16'h0, 0,1,0,16'h0047,16'h0,1,2'd3,16'hA3,0});
    tbl.push_back(vec_t'{1,1,0,0,0,16'h0,16'h0047,16'h0,  0,0,0,16'h0,16'h0,0,2'd0,16'h0,1});
    tbl.push_back(vec_t'{1,1,0,0,0,16'h0,16'h0047,16'h0,  1,0,0,16'h0,16'h0,0,2'd0,16'h0,0});
    tbl.push_back(vec_t'{1,0,0,0,0,16'h0,16'h0,16'h0,     1,0,0,16'h0,16'h0,0,2'd0,16'h0,0});
    // write 0x0010 <- BEEF, tag hit, ack on third WRITE cycle
    tbl.push_back(vec_t'{1,0,1,1,0,16'h0,16'h0010,16'hBEEF, 0,0,0,16'h0,16'h0,0,2'd0,16'h0,0});
    tbl.push_back(vec_t'{1,0,1,1,0,16'h0,16'h0010,16'hBEEF, 0,1,1,16'h0010,16'hBEEF,0,2'd0,16'h0,0});
    tbl.push_back(vec_t'{1,0,1,1,0,16'h0,16'h0010,16'hBEEF, 0,1,1,16'h0010,16'hBEEF,0,2'd0,16'h0,0});
    tbl.push_back(vec_t'{1,0,1,1,1,16'h0,16'h0010,16'hBEEF, 0,1,1,16'h0010,16'hBEEF,1,2'd0,16'hBEEF,0});
    tbl.push_back(vec_t'{1,0,1,1,0,16'h0,16'h0010,16'hBEEF, 1,0,0,16'h0,16'h0,0,2'd0,16'h0,0});
    tbl.push_back(vec_t'{1,0,0,0,0,16'h0,16'h0,16'h0,       1,0,0,16'h0,16'h0,0,2'd0,16'h0,0});
    // read+write together with spurious ack in IDLE; write wins, no tag hit
    tbl.push_back(vec_t'{1,1,1,0,1,16'h1234,16'h0023,16'h5555, 0,0,0,16'h0,16'h0,0,2'd0,16'h0,0});
    tbl.push_back(vec_t'{1,1,1,0,0,16'h0,16'h0023,16'h5555,    0,1,1,16'h0023,16'h5555,0,2'd0,16'h0,0});
    tbl.push_back(vec_t'{1,1,1,0,1,16'h0,16'h0023,16'h5555,    0,1,1,16'h0023,16'h5555,0,2'd0,16'h0,0});
    tbl.push_back(vec_t'{1,1,1,0,0,16'h0,16'h0023,16'h5555,    1,0,0,16'h0,16'h0,0,2'd0,16'h0,0});
    tbl.push_back(vec_t'{1,0,0,0,0,16'h0,16'h0,16'h0,          1,0,0,16'h0,16'h0,0,2'd0,16'h0,0});

    @(posedge inp_clk); #1;
    foreach (tbl[i]) begin
      inp_rstn = tbl[i].rstn; inp_memRead = tbl[i].rd; inp_memWrite = tbl[i].wr;
      inp_tagHit = tbl[i].tag; inp_memAck = tbl[i].ack; inp_memData = tbl[i].memData;
      inp_addr = tbl[i].addr; inp_wdata = tbl[i].wdata;
      @(negedge inp_clk);
      chk($sformatf("vec%0d", i), outVec(), expVec(tbl[i]));
      @(posedge inp_clk); #1;
    end

`ifdef MEM_STALL_MISS_CNT_EN
    chk("missCnt_after_one_miss", 64'(out_missCnt), 64'd1);
`endif

    // Reset after the second fill ack: miss at 0x0083, line base 0x0080.
    inp_memRead = 1'b1; inp_addr = 16'h0083; inp_tagHit = 1'b0; inp_memAck = 1'b0;
    @(posedge inp_clk); #1;
    inp_memAck = 1'b1; inp_memData = 16'h0011;
    @(posedge inp_clk); #1;
    inp_memData = 16'h0022;
    @(posedge inp_clk); #1;
    inp_memAck = 1'b0; inp_rstn = 1'b0;
    @(negedge inp_clk);
    chk("fill_req_before_reset", {out_memReq, out_memAddr}, {1'b1, 16'h0082});
    @(posedge inp_clk); #1;
    inp_memRead = 1'b0;
    @(negedge inp_clk);
    chk("req_dropped_after_reset", {out_memReq, out_hit, out_fillWe}, {1'b0, 1'b1, 1'b0});
`ifdef MEM_STALL_MISS_CNT_EN
    chk("missCnt_cleared", 64'(out_missCnt), 64'd0);
`endif
    inp_rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge inp_clk); #1;
      @(negedge inp_clk);
      chk($sformatf("no_tag_after_reset%0d", k), {out_tagWe, out_memReq, out_hit}, {1'b0, 1'b0, 1'b1});
    end

    // A fresh miss to the same line restarts the fill at word 0.
    @(posedge inp_clk); #1;
    inp_memRead = 1'b1; inp_addr = 16'h0083;
    @(posedge inp_clk); #1;
    @(negedge inp_clk);
    chk("refill_starts_word0", {out_memReq, out_memAddr, out_hit}, {1'b1, 16'h0080, 1'b0});

    inp_rstn = 1'b0; inp_memRead = 1'b0;
    @(posedge inp_clk); #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
